// File: rtl/int_multiplier.sv
// Sequential shift-and-add integer multiplier with a go/done handshake.
// Define MULT_SIGNED_EN to build the two's-complement (signed) variant.
module int_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   p,
  output logic                 done,
  output logic [2:0]           cs
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOAD  = 3'b001,
    S_TEST  = 3'b010,
    S_SHIFT = 3'b011,
    S_FIX   = 3'b100,
    S_DONE  = 3'b101
  } state_e;

  state_e          state_q, state_d;
  logic            load_en, test_en, shift_en, fix_en;
  logic [PW-1:0]   a_q, a_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [PW-1:0]   result;

  // ---------------------------------------------------------------------------
  // Control FSM: every enable is a pure decode of the current state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    load_en  = 1'b0;
    test_en  = 1'b0;
    shift_en = 1'b0;
    fix_en   = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE:  if (go) state_d = S_LOAD;
      S_LOAD: begin
        load_en = 1'b1;
        state_d = S_TEST;
      end
      S_TEST: begin
        test_en = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        state_d  = (cnt_q == '0) ? S_FIX : S_TEST;
      end
      S_FIX: begin
        fix_en  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning and final result selection.
  // ---------------------------------------------------------------------------
`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct magnitude
  // when read as unsigned.
  assign x_mag  = x[WIDTH-1] ? -x : x;
  assign y_mag  = y[WIDTH-1] ? -y : y;
  assign neg_d  = load_en ? (x[WIDTH-1] ^ y[WIDTH-1]) : neg_q;
  assign result = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end
`else
  assign x_mag  = x;
  assign y_mag  = y;
  assign result = acc_q;
`endif

  // ---------------------------------------------------------------------------
  // Datapath next-state.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    p_d   = p_q;
    if (load_en) begin
      a_d   = {{WIDTH{1'b0}}, x_mag};
      b_d   = y_mag;
      acc_d = '0;
      cnt_d = CW'(WIDTH);
    end
    if (test_en) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      cnt_d = cnt_q - CW'(1);
    end
    if (shift_en) begin
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end
    if (fix_en) p_d = result;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign cs = state_q;
  assign p  = p_q;

endmodule

// File: tb/tb_int_multiplier.sv
// Scoreboard bench for int_multiplier (WIDTH = 4); expected products and
// done-cycle deadlines are queued at issue time and checked by a monitor.
module tb_int_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [3:0] x, y;
  logic [7:0] p;
  logic       done;
  logic [2:0] cs;

  int_multiplier #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .x    (x),
    .y    (y),
    .p    (p),
    .done (done),
    .cs   (cs)
  );

  always #5 clk = ~clk;

`ifdef MULT_SIGNED_EN
  localparam logic [7:0] P_13_11 = 8'h0F;  // -3 * -5
  localparam logic [7:0] P_15_15 = 8'h01;  // -1 * -1
  localparam logic [7:0] P_0_9   = 8'h00;  //  0 * -7
  localparam logic [7:0] P_8_8   = 8'h40;  // -8 * -8
  localparam logic [7:0] P_13_5  = 8'hF1;  // -3 *  5
`else
  localparam logic [7:0] P_13_11 = 8'h8F;
  localparam logic [7:0] P_15_15 = 8'hE1;
  localparam logic [7:0] P_0_9   = 8'h00;
  localparam logic [7:0] P_8_8   = 8'h40;
  localparam logic [7:0] P_13_5  = 8'h41;
`endif

  typedef struct {
    logic [7:0] p;
    int         due;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic done_prev = 1'b0;

  logic [2:0] cs_exp [12] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd2,
                              3'd3, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [7:0] pv, input string nm, input int due);
    exp_t e;
    e.p    = pv;
    e.due  = due;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Called at a negedge with the DUT in IDLE: the next posedge is E0, so
  // done must be observed at the negedge following E0+10.
  task automatic issue(input logic [3:0] xv, input logic [3:0] yv,
                       input logic [7:0] pv, input string nm);
    x  = xv;
    y  = yv;
    go = 1'b1;
    push_exp(pv, nm, cyc + 1 + 10);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("done_single_cycle", done_prev, 1'b0);
        if (sb.size() == 0) begin
          check("spurious_done", done, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_p"}, p, mon_e.p);
          check({mon_e.name, "_latency"}, cyc, mon_e.due);
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    x   = '0;
    y   = '0;
    repeat (2) @(negedge clk);
    check("reset_cs", cs, 3'd0);
    check("reset_done", done, 1'b0);
    check("reset_p", p, 8'h00);
    rst = 1'b0;

    // Basic operation with full state-sequence trace.
    @(negedge clk);
    issue(4'd13, 4'd11, P_13_11, "m13x11");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) go = 1'b0;
      check($sformatf("cs_seq_%0d", k), cs, cs_exp[k]);
    end
    drain();

    // Directed vectors including the extreme and zero operands.
    @(negedge clk); issue(4'd15, 4'd15, P_15_15, "m15x15");
    @(negedge clk); go = 1'b0;
    drain();
    @(negedge clk); issue(4'd0, 4'd9, P_0_9, "m0x9");
    @(negedge clk); go = 1'b0;
    drain();
    @(negedge clk); issue(4'd8, 4'd8, P_8_8, "m8x8");
    @(negedge clk); go = 1'b0;
    drain();
    @(negedge clk); issue(4'd13, 4'd5, P_13_5, "m13x5");
    @(negedge clk); go = 1'b0;
    drain();

    // Inputs change after LOAD and go pulses mid-operation.
    @(negedge clk); issue(4'd7, 4'd6, 8'd42, "stable");
    @(negedge clk); go = 1'b0;
    @(negedge clk); x = 4'd0; y = 4'd0;
    repeat (3) @(negedge clk);
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    check("stable_back_idle", cs, 3'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    x = 4'd9; y = 4'd9; go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_cs", cs, 3'd0);
    check("midrst_done", done, 1'b0);
    check("midrst_p", p, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); issue(4'd7, 4'd6, 8'd42, "post_rst");
    @(negedge clk); go = 1'b0;
    drain();

    // Back-to-back with go held high; second LOAD state appears after E12.
    @(negedge clk);
    issue(4'd3, 4'd5, 8'd15, "b2b_a");
    push_exp(8'd4, "b2b_b", cyc + 1 + 22);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 10) begin
        x = 4'd2;
        y = 4'd2;
      end
      if (k == 12) begin
        check("b2b_second_load", cs, 3'd1);
        check("b2b_p_hold", p, 8'd15);
        go = 1'b0;
      end
    end
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
